// File: rtl/id_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : id_hazard_ctrl_pkg
// Purpose  : Shared constants for the decode-stage controller and for any
//            other pipeline stage that reuses the immediate-select decoder.
//            Holds RV32 base opcodes, immediate-select codes, the canonical
//            NOP encoding and the decode FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package id_hazard_ctrl_pkg;

    // ------------------------------------------------------------------------
    // RV32 base opcodes (inst[6:0])
    // ------------------------------------------------------------------------
    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP     = 7'b0110011;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_LUI    = 7'b0110111;
    localparam logic [6:0] c_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_JAL    = 7'b1101111;
    localparam logic [6:0] c_JALR   = 7'b1100111;

    // ------------------------------------------------------------------------
    // Immediate-generator select codes. IMM_J covers both JAL and JALR; the
    // generator looks at inst[3] to pick the J or I layout.
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_U = 3'b011;
    localparam logic [2:0] c_IMM_J = 3'b100;

    // addi x0, x0, 0
    localparam logic [31:0] c_NOP_INST = 32'h0000_0013;

    // ------------------------------------------------------------------------
    // Decode FSM state encodings
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_STALL = 1'b1;

    // Width of the per-hazard stall down-counter (supports up to 7 cycles).
    localparam int c_STALL_CNT_W = 3;

endpackage : id_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/id_hazard_ctrl_imm_sel_dec.sv
`default_nettype none
// ============================================================================
// Module   : imm_sel_dec
// Purpose  : Purely combinational opcode classifier. Produces the immediate
//            select for the immediate generator, the source-register usage
//            flags used by hazard detection, and an opcode-recognised flag.
// Ports    : i_opcode    - inst[6:0]
//            o_immsel    - immediate select (IMM_I/S/B/U/J)
//            o_uses_rs1  - instruction reads rs1
//            o_uses_rs2  - instruction reads rs2
//            o_known     - opcode belongs to the supported base set
// Revision : 1.0 - initial release
// ============================================================================
module imm_sel_dec
    import id_hazard_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [2:0] o_immsel,
    output logic       o_uses_rs1,
    output logic       o_uses_rs2,
    output logic       o_known
);

    always_comb begin
        o_immsel = c_IMM_I;
        o_known  = 1'b1;
        case (i_opcode)
            c_OP_IMM, c_LOAD, c_SYSTEM, c_OP: o_immsel = c_IMM_I;
            c_STORE:                          o_immsel = c_IMM_S;
            c_BRANCH:                         o_immsel = c_IMM_B;
            c_LUI, c_AUIPC:                   o_immsel = c_IMM_U;
            c_JAL, c_JALR:                    o_immsel = c_IMM_J;
            default: begin
                o_immsel = c_IMM_I;
                o_known  = 1'b0;
            end
        endcase
    end

    // Only U-type and JAL lack an rs1 field; unknown opcodes are treated
    // conservatively as reading rs1 so they can still trigger a stall.
    always_comb begin
        o_uses_rs1 = !((i_opcode == c_LUI) || (i_opcode == c_AUIPC) ||
                       (i_opcode == c_JAL));
        o_uses_rs2 = (i_opcode == c_OP) || (i_opcode == c_STORE) ||
                     (i_opcode == c_BRANCH);
    end

endmodule : imm_sel_dec
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_ctrl
// Purpose  : Decode-stage controller. Owns the IF/ID pipeline register,
//            decodes the latched opcode into the immediate select, detects
//            load-use hazards against EX, sequences stall cycles with a
//            two-state FSM and applies branch-taken flushes.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_if_inst/pc/valid  - fetched instruction, its PC, valid
//            i_ex_memread/rd/valid - EX-stage load flag, dest reg, valid
//            i_br_taken          - redirect; flushes IF/ID
//            o_id_inst/pc/valid  - IF/ID register contents
//            o_immsel            - immediate select for o_id_inst
//            o_rs1/o_rs2/o_rd    - register fields of o_id_inst
//            o_pc_stall          - hold PC and fetch this cycle
//            o_bubble            - ID/EX must load a NOP this cycle
//            o_illegal           - valid instruction with unknown opcode
//            o_hzd_cnt           - saturating count of detected hazards
// Revision : 1.0 - initial release
// ============================================================================
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int WID_DATA  = 32,
    parameter int STALL_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WID_DATA-1:0] i_if_inst,
    input  logic [WID_DATA-1:0] i_if_pc,
    input  logic                i_if_valid,
    input  logic                i_ex_memread,
    input  logic [4:0]          i_ex_rd,
    input  logic                i_ex_valid,
    input  logic                i_br_taken,
    output logic [WID_DATA-1:0] o_id_inst,
    output logic [WID_DATA-1:0] o_id_pc,
    output logic                o_id_valid,
    output logic [2:0]          o_immsel,
    output logic [4:0]          o_rs1,
    output logic [4:0]          o_rs2,
    output logic [4:0]          o_rd,
    output logic                o_pc_stall,
    output logic                o_bubble,
    output logic                o_illegal,
    output logic [CNT_W-1:0]    o_hzd_cnt
);

    // Counter preload: the RUN cycle that detects the hazard is the first
    // stall cycle, so STALL only has to cover the remaining STALL_CYC-1.
    localparam logic [c_STALL_CNT_W-1:0] c_STALL_LOAD =
        c_STALL_CNT_W'(STALL_CYC - 1);
    localparam logic [WID_DATA-1:0]      c_NOP = WID_DATA'(c_NOP_INST);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]               r_state;
    logic [c_STALL_CNT_W-1:0] r_cnt;
    logic [WID_DATA-1:0]      r_id_inst;
    logic [WID_DATA-1:0]      r_id_pc;
    logic                     r_id_valid;
    logic [CNT_W-1:0]         r_hzd_cnt;

    // ------------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------------
    logic [0:0]               w_state_nxt;
    logic [c_STALL_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]               w_immsel;
    logic                     w_uses_rs1;
    logic                     w_uses_rs2;
    logic                     w_known;
    logic [4:0]               w_rs1;
    logic [4:0]               w_rs2;
    logic [4:0]               w_rd;
    logic                     w_hazard;
    logic                     w_pc_stall;
    logic                     w_ifid_load;
    logic                     w_hzd_inc;

    // ------------------------------------------------------------------------
    // Field extraction and opcode decode
    // ------------------------------------------------------------------------
    assign w_rs1 = r_id_inst[19:15];
    assign w_rs2 = r_id_inst[24:20];
    assign w_rd  = r_id_inst[11:7];

    imm_sel_dec u_imm_sel_dec (
        .i_opcode   (r_id_inst[6:0]),
        .o_immsel   (w_immsel),
        .o_uses_rs1 (w_uses_rs1),
        .o_uses_rs2 (w_uses_rs2),
        .o_known    (w_known)
    );

    // Load-use hazard: the load in EX will not have its data until after
    // the ID instruction would read it. x0 is hard-wired, never a hazard.
    always_comb begin
        w_hazard = r_id_valid && i_ex_valid && i_ex_memread &&
                   (i_ex_rd != 5'd0) &&
                   ((w_uses_rs1 && (w_rs1 == i_ex_rd)) ||
                    (w_uses_rs2 && (w_rs2 == i_ex_rd)));
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_br_taken) begin
            // Redirect wins over any stall in progress.
            w_state_nxt = c_ST_RUN;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    // With a single stall cycle there is nothing to count;
                    // the hazard is simply re-evaluated next cycle in RUN.
                    if (w_hazard && (STALL_CYC > 1)) begin
                        w_state_nxt = c_ST_STALL;
                        w_cnt_nxt   = c_STALL_LOAD;
                    end
                end
                c_ST_STALL: begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    // cnt==0 cannot occur here; leave defensively.
                    if (r_cnt <= c_STALL_CNT_W'(1)) begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_pc_stall  = 1'b0;
        w_ifid_load = 1'b0;
        w_hzd_inc   = 1'b0;
        // A taken branch must never be stalled: the redirect has to land.
        if (!i_br_taken) begin
            case (r_state)
                c_ST_RUN: begin
                    w_pc_stall  = w_hazard;
                    w_ifid_load = !w_hazard;
                    w_hzd_inc   = w_hazard;
                end
                c_ST_STALL: begin
                    w_pc_stall = 1'b1;
                end
                default: begin
                    w_pc_stall = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID register and hazard counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_inst  <= c_NOP;
            r_id_pc    <= '0;
            r_id_valid <= 1'b0;
            r_hzd_cnt  <= '0;
        end else begin
            if (i_br_taken) begin
                r_id_inst  <= c_NOP;
                r_id_valid <= 1'b0;
            end else if (w_ifid_load) begin
                // Invalid fetch slots are squashed to a NOP so the decoder
                // never sees stale encodings.
                r_id_inst  <= i_if_valid ? i_if_inst : c_NOP;
                r_id_pc    <= i_if_pc;
                r_id_valid <= i_if_valid;
            end

            if (w_hzd_inc && (r_hzd_cnt != {CNT_W{1'b1}})) begin
                r_hzd_cnt <= r_hzd_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_id_inst  = r_id_inst;
    assign o_id_pc    = r_id_pc;
    assign o_id_valid = r_id_valid;
    assign o_immsel   = w_immsel;
    assign o_rs1      = w_rs1;
    assign o_rs2      = w_rs2;
    assign o_rd       = w_rd;
    assign o_pc_stall = w_pc_stall;
    assign o_bubble   = !r_id_valid || w_pc_stall;
    assign o_illegal  = r_id_valid && !w_known;
    assign o_hzd_cnt  = r_hzd_cnt;

endmodule : id_hazard_ctrl
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_hazard_ctrl
// Purpose  : Self-checking bench for id_hazard_ctrl. Two instances share the
//            same stimulus: one with a single stall cycle per hazard, one
//            with three. Directed scenarios plus a randomized run compared
//            against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_hazard_ctrl;

    localparam logic [31:0] c_NOP  = 32'h0000_0013;
    localparam logic [31:0] c_ADD  = 32'h0022_8333; // add x6, x5, x2
    localparam logic [31:0] c_NEXT = 32'h00A0_0093; // addi x1, x0, 10

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_valid;
    logic        br_taken;

    logic [31:0] a_inst, b_inst, a_pc, b_pc;
    logic        a_valid, b_valid;
    logic [2:0]  a_immsel, b_immsel;
    logic [4:0]  a_rs1, b_rs1, a_rs2, b_rs2, a_rd, b_rd;
    logic        a_stall, b_stall, a_bubble, b_bubble, a_illegal, b_illegal;
    logic [15:0] a_hcnt, b_hcnt;

    id_hazard_ctrl #(.WID_DATA(32), .STALL_CYC(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_if_inst(if_inst), .i_if_pc(if_pc), .i_if_valid(if_valid),
        .i_ex_memread(ex_memread), .i_ex_rd(ex_rd), .i_ex_valid(ex_valid),
        .i_br_taken(br_taken),
        .o_id_inst(a_inst), .o_id_pc(a_pc), .o_id_valid(a_valid),
        .o_immsel(a_immsel), .o_rs1(a_rs1), .o_rs2(a_rs2), .o_rd(a_rd),
        .o_pc_stall(a_stall), .o_bubble(a_bubble), .o_illegal(a_illegal),
        .o_hzd_cnt(a_hcnt)
    );

    id_hazard_ctrl #(.WID_DATA(32), .STALL_CYC(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_if_inst(if_inst), .i_if_pc(if_pc), .i_if_valid(if_valid),
        .i_ex_memread(ex_memread), .i_ex_rd(ex_rd), .i_ex_valid(ex_valid),
        .i_br_taken(br_taken),
        .o_id_inst(b_inst), .o_id_pc(b_pc), .o_id_valid(b_valid),
        .o_immsel(b_immsel), .o_rs1(b_rs1), .o_rs2(b_rs2), .o_rd(b_rd),
        .o_pc_stall(b_stall), .o_bubble(b_bubble), .o_illegal(b_illegal),
        .o_hzd_cnt(b_hcnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // ------------------------------------------------------------------------
    // Behavioural model: per instance, IF/ID contents, the number of stall
    // cycles still owed after the current one, and the hazard tally.
    // ------------------------------------------------------------------------
    int          stalls [2] = '{1, 3};
    logic [31:0] m_inst [2];
    logic [31:0] m_pc   [2];
    logic        m_valid[2];
    int          m_owed [2];
    int          m_hcnt [2];

    function automatic logic [2:0] ref_imm(input logic [6:0] op);
        case (op)
            7'h13, 7'h03, 7'h73, 7'h33: return 3'd0;
            7'h23:                      return 3'd1;
            7'h63:                      return 3'd2;
            7'h37, 7'h17:               return 3'd3;
            7'h6F, 7'h67:               return 3'd4;
            default:                    return 3'd0;
        endcase
    endfunction

    function automatic logic ref_known(input logic [6:0] op);
        return op inside {7'h13, 7'h03, 7'h73, 7'h33, 7'h23, 7'h63,
                          7'h37, 7'h17, 7'h6F, 7'h67};
    endfunction

    function automatic logic ref_hazard(input int k);
        logic [6:0] op;
        logic       u1, u2;
        op = m_inst[k][6:0];
        u1 = !(op inside {7'h37, 7'h17, 7'h6F});
        u2 = op inside {7'h33, 7'h23, 7'h63};
        return m_valid[k] && ex_valid && ex_memread && (ex_rd != 0) &&
               ((u1 && m_inst[k][19:15] == ex_rd) ||
                (u2 && m_inst[k][24:20] == ex_rd));
    endfunction

    function automatic logic ref_stall(input int k);
        return !br_taken && ((m_owed[k] > 0) || ref_hazard(k));
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_inst[k] = c_NOP; m_pc[k] = 0; m_valid[k] = 0;
                m_owed[k] = 0;     m_hcnt[k] = 0;
            end else if (br_taken) begin
                m_inst[k] = c_NOP; m_valid[k] = 0; m_owed[k] = 0;
            end else if (m_owed[k] > 0) begin
                m_owed[k]--;
            end else if (ref_hazard(k)) begin
                if (m_hcnt[k] < 65535) m_hcnt[k]++;
                m_owed[k] = stalls[k] - 1;
            end else begin
                m_inst[k]  = if_valid ? if_inst : c_NOP;
                m_pc[k]    = if_pc;
                m_valid[k] = if_valid;
            end
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; if_inst = c_NOP; if_pc = 0; if_valid = 0;
        ex_memread = 0; ex_rd = 0; ex_valid = 0; br_taken = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    // Reset, then load c_ADD into IF/ID of both instances.
    task automatic load_add();
        do_reset();
        if_inst = c_ADD; if_pc = 32'h100; if_valid = 1;
        tick();
        if_inst = c_NEXT; if_pc = 32'h104;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({a_valid, a_inst, a_pc, a_bubble, a_stall, a_hcnt, a_immsel, a_illegal}
            !== {1'b0, c_NOP, 32'h0, 1'b1, 1'b0, 16'h0, 3'b000, 1'b0}) begin
            n_err++;
            $display("FAIL reset_dut1 got v=%b i=%h pc=%h bub=%b st=%b h=%0d imm=%b ill=%b",
                     a_valid, a_inst, a_pc, a_bubble, a_stall, a_hcnt, a_immsel, a_illegal);
        end
        n_vec++;
        if ({b_valid, b_inst, b_pc, b_bubble, b_stall, b_hcnt}
            !== {1'b0, c_NOP, 32'h0, 1'b1, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL reset_dut3 got v=%b i=%h pc=%h bub=%b st=%b h=%0d",
                     b_valid, b_inst, b_pc, b_bubble, b_stall, b_hcnt);
        end
    endtask

    task automatic test_decode();
        logic [31:0] insts [4] = '{32'h123453B7, 32'h00512223, 32'h008000EF, 32'hFFFFFFFF};
        logic [2:0]  imms  [4] = '{3'b011, 3'b001, 3'b100, 3'b000};
        logic        ills  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if_inst = insts[i]; if_pc = 32'h200 + 32'(4 * i); if_valid = 1;
            tick();
            n_vec++;
            if ({a_inst, a_immsel, a_illegal} !== {insts[i], imms[i], ills[i]}) begin
                n_err++;
                $display("FAIL decode_%0d got inst=%h imm=%b ill=%b exp inst=%h imm=%b ill=%b",
                         i, a_inst, a_immsel, a_illegal, insts[i], imms[i], ills[i]);
            end
        end
    endtask

    task automatic test_load_use_1();
        load_add();
        ex_valid = 1; ex_memread = 1; ex_rd = 5;
        #1;
        n_vec++;
        if ({a_stall, a_bubble, a_hcnt} !== {1'b1, 1'b1, 16'd0}) begin
            n_err++;
            $display("FAIL lu1_detect got stall=%b bub=%b h=%0d exp 1 1 0", a_stall, a_bubble, a_hcnt);
        end
        tick();
        ex_memread = 0;
        #1;
        n_vec++;
        if ({a_inst, a_hcnt, a_stall} !== {c_ADD, 16'd1, 1'b0}) begin
            n_err++;
            $display("FAIL lu1_hold got inst=%h h=%0d stall=%b exp %h 1 0", a_inst, a_hcnt, a_stall, c_ADD);
        end
        tick();
        n_vec++;
        if ({a_inst, a_pc} !== {c_NEXT, 32'h104}) begin
            n_err++;
            $display("FAIL lu1_advance got inst=%h pc=%h exp %h 104", a_inst, a_pc, c_NEXT);
        end
    endtask

    task automatic test_load_use_3();
        int cnt;
        load_add();
        ex_valid = 1; ex_memread = 1; ex_rd = 5;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (b_stall) cnt++;
            tick();
            ex_memread = 0;
        end
        n_vec++;
        if (cnt !== 3 || b_hcnt !== 16'd1) begin
            n_err++;
            $display("FAIL lu3_len got stall_cycles=%0d h=%0d exp 3 1", cnt, b_hcnt);
        end
        // Same instruction, load writes x0: never a hazard.
        if_inst = c_ADD;
        tick();
        ex_memread = 1; ex_rd = 0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (b_stall || a_stall) cnt++;
            tick();
        end
        n_vec++;
        if (cnt !== 0 || b_inst !== c_ADD) begin
            n_err++;
            $display("FAIL lu3_x0 got stall_cycles=%0d inst=%h exp 0 %h", cnt, b_inst, c_ADD);
        end
    endtask

    task automatic test_flush_mid_stall();
        load_add();
        ex_valid = 1; ex_memread = 1; ex_rd = 2;   // hits rs2
        tick();
        ex_memread = 0;
        #1;
        n_vec++;
        if (b_stall !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pre got stall=%b exp 1", b_stall);
        end
        br_taken = 1;
        #1;
        n_vec++;
        if (b_stall !== 1'b0 || a_stall !== 1'b0) begin
            n_err++;
            $display("FAIL flush_cycle_stall got dut3=%b dut1=%b exp 0 0", b_stall, a_stall);
        end
        tick();
        br_taken = 0;
        #1;
        n_vec++;
        if ({b_valid, b_inst, b_stall, b_hcnt} !== {1'b0, c_NOP, 1'b0, 16'd1}) begin
            n_err++;
            $display("FAIL flush_after got v=%b inst=%h stall=%b h=%0d exp 0 %h 0 1",
                     b_valid, b_inst, b_stall, b_hcnt, c_NOP);
        end
        tick();
        n_vec++;
        if ({b_valid, b_inst} !== {1'b1, c_NEXT}) begin
            n_err++;
            $display("FAIL flush_resume got v=%b inst=%h exp 1 %h", b_valid, b_inst, c_NEXT);
        end
    endtask

    task automatic test_reset_mid_stall();
        load_add();
        ex_valid = 1; ex_memread = 1; ex_rd = 5;
        tick();
        ex_memread = 0;
        rst = 1; if_valid = 1; if_inst = c_NEXT;
        tick();
        rst = 0;
        #1;
        n_vec++;
        if ({b_valid, b_inst, b_pc, b_stall, b_bubble, b_hcnt}
            !== {1'b0, c_NOP, 32'h0, 1'b0, 1'b1, 16'd0}) begin
            n_err++;
            $display("FAIL rst_mid_stall got v=%b inst=%h pc=%h stall=%b bub=%b h=%0d",
                     b_valid, b_inst, b_pc, b_stall, b_bubble, b_hcnt);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h73, 7'h33, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
        logic [31:0] r;
        logic [31:0] exp_inst, exp_pc;
        logic        exp_v, exp_st;
        logic [2:0]  exp_imm;
        logic [15:0] exp_h;
        logic [98:0] got, exp;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_inst[k] = c_NOP; m_pc[k] = 0; m_valid[k] = 0; m_owed[k] = 0; m_hcnt[k] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            r          = $urandom;
            rst        = ($urandom_range(0, 63) == 0);
            br_taken   = ($urandom_range(0, 7) == 0);
            if_valid   = ($urandom_range(0, 4) != 0);
            if_inst    = {r[31:25], 3'(r[2:0]) == 0 ? 5'd0 : 5'(r[4:3]), 5'(r[6:5]),
                          r[14:12], 5'(r[8:7]), ops[$urandom_range(0, 10)]};
            if_pc      = $urandom;
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_memread = ($urandom_range(0, 1) != 0);
            ex_rd      = 5'($urandom_range(0, 3));
            #1;
            for (int k = 0; k < 2; k++) begin
                exp_inst = m_inst[k];
                exp_pc   = m_pc[k];
                exp_v    = m_valid[k];
                exp_imm  = ref_imm(exp_inst[6:0]);
                exp_st   = ref_stall(k);
                exp_h    = 16'(m_hcnt[k]);
                exp = {exp_inst, exp_pc, exp_v, exp_imm, exp_inst[19:15], exp_inst[24:20],
                       exp_inst[11:7], exp_st, !exp_v || exp_st,
                       exp_v && !ref_known(exp_inst[6:0]), exp_h};
                if (k == 0)
                    got = {a_inst, a_pc, a_valid, a_immsel, a_rs1, a_rs2, a_rd,
                           a_stall, a_bubble, a_illegal, a_hcnt};
                else
                    got = {b_inst, b_pc, b_valid, b_immsel, b_rs1, b_rs2, b_rd,
                           b_stall, b_bubble, b_illegal, b_hcnt};
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL random dut=%0d cyc=%0d got=%h exp=%h", k, cyc, got, exp);
                end
            end
            model_step();
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_decode();
        test_load_use_1();
        test_load_use_3();
        test_flush_mid_stall();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_id_hazard_ctrl
`default_nettype wire

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
Decode-stage controller for the 32-bit RISC-V pipeline. Owns the IF/ID pipeline register and decodes the latched instruction's opcode into the 3-bit immsel that drives the immediate generator. It also detects load-use hazards against the EX stage, sequences stall cycles with a small FSM, and handles branch-taken flushes. Sits between fetch and the ID/EX register.

Parameters:
WID_DATA, 32, instruction/PC width
STALL_CYC, 1, stall cycles inserted per load-use hazard (legal 1..7)
CNT_W, 16, width of saturating hazard counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
if_inst  input  WID_DATA  fetched instruction
if_pc  input  WID_DATA  PC of if_inst
if_valid  input  1  if_inst is valid
ex_memread  input  1  EX-stage instruction is a load
ex_rd  input  5  EX-stage destination register
ex_valid  input  1  EX-stage instruction is valid
br_taken  input  1  branch/jump resolved taken; flush
id_inst  output  WID_DATA  IF/ID instruction register
id_pc  output  WID_DATA  IF/ID PC register
id_valid  output  1  IF/ID valid
immsel  output  3  immediate select for id_inst (comb.)
rs1, rs2, rd  output  5 each  register fields of id_inst (comb.)
pc_stall  output  1  hold PC and fetch this cycle (comb.)
bubble  output  1  ID/EX must load a NOP this cycle (comb.)
illegal  output  1  id_valid and opcode unrecognised (comb.)
hzd_cnt  output  CNT_W  saturating count of hazards detected

Behaviour:
- Reset (rst=1 at posedge): id_inst=32'h00000013 (NOP), id_pc=0, id_valid=0, state=RUN, stall counter=0, hzd_cnt=0. Combinational outputs follow from these: immsel=000, pc_stall=0, bubble=1, illegal=0.
- immsel decode (id_inst[6:0]):
  - 0010011, 0000011, 1110011, 0110011 -> 000
  - 0100011 -> 001
  - 1100011 -> 010
  - 0110111, 0010111 -> 011
  - 1101111, 1100111 -> 100 (the generator uses inst[3] to pick J vs I form)
  - Any other opcode -> 000, and illegal = id_valid.
- Register use flags:
  - uses_rs1 = not (LUI, AUIPC, JAL).
  - uses_rs2 = R-type, S-type or B-type.
- hazard (comb.) = id_valid & ex_valid & ex_memread & (ex_rd!=0) & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- FSM states RUN and STALL, with a 3-bit counter cnt.
  - RUN, hazard=0: pc_stall=0. IF/ID loads if_inst, if_pc and if_valid. If if_valid=0, id_inst loads NOP.
  - RUN, hazard=1: pc_stall=1, IF/ID holds, hzd_cnt increments (saturating at all-ones). If STALL_CYC>1: next state STALL, cnt=STALL_CYC-1. Otherwise stay in RUN; hazard is re-evaluated next cycle.
  - STALL: pc_stall=1, IF/ID holds, hazard is ignored, cnt decrements. When cnt==1, the next state is RUN.
- Total stall per hazard = STALL_CYC cycles.
- bubble = ~id_valid | pc_stall.
- br_taken has highest priority, in either state:
  - At the posedge: id_inst=NOP, id_valid=0, state=RUN, cnt=0.
  - In that cycle: pc_stall=0 (the PC redirect must proceed) and hzd_cnt does not increment.
- rst has priority over br_taken. Reset in mid-STALL returns to RUN on the next edge.
- x0 destination never causes a hazard.
- Latency: if_inst appears on id_inst 1 cycle after capture. immsel is valid in the same cycle as id_inst.

Decomposition:
- Shared package holds:
  - opcode constants (OP_IMM, LOAD, SYSTEM, OP, STORE, BRANCH, LUI, AUIPC, JAL, JALR)
  - IMM_I=3'b000, IMM_S=001, IMM_B=010, IMM_U=011, IMM_J=100
  - NOP_INST=32'h00000013
  - FSM state encodings
- Sub-module imm_sel_dec: purely combinational. Maps opcode to immsel, uses_rs1, uses_rs2 and opcode-known. It is reused by other stages.

Test Plan:
- Reset, then if_valid=0 -> id_valid=0, id_inst=0x00000013, bubble=1, pc_stall=0, hzd_cnt=0.
- Sequential decode: feed 0x123453B7 (lui), 0x00512223 (sw), 0x008000EF (jal), 0xFFFFFFFF (bad) -> immsel 011, 001, 100, 000 in consecutive cycles; illegal=1 only on the last.
- Load-use, STALL_CYC=1:
  - Setup: ex_valid=1, ex_memread=1, ex_rd=5, with id_inst=0x00228333 (add x6,x5,x2).
  - Expect: pc_stall=1 and bubble=1 for 1 cycle, id_inst held, hzd_cnt=1.
  - Next cycle, with ex_memread=0: IF/ID advances.
- STALL_CYC=3 with the same hazard -> pc_stall high exactly 3 cycles. Repeat with ex_rd=0 -> no stall.
- br_taken in the 2nd STALL cycle -> next edge id_valid=0, id_inst=NOP, state RUN, pc_stall=0 in the flush cycle.
- rst asserted mid-STALL with if_valid=1 -> next edge matches the reset values; no IF/ID load.
